// File: rtl/alu_multicycle.sv
// Execute-stage ALU: single-cycle logic/arith/shift ops plus an iterative
// signed multiply-accumulate (MULA) into a 64-bit accumulator.
//   state | meaning
//   IDLE  | accepts Start/AccClr, retires single-cycle ops
//   MUL   | shift-add of MUL_STEP_BITS multiplier bits per cycle
//   FIN   | signs the product, folds it into the accumulator, pulses Done
module alu_multicycle #(
  parameter int WIDTH         = 32,
  parameter int MUL_STEP_BITS = 1
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Start,
  input  logic [3:0]       ALUCtrl,
  input  logic [WIDTH-1:0] BusA,
  input  logic [WIDTH-1:0] BusB,
  input  logic [4:0]       Shamt,
  input  logic             AccClr,
  output logic [WIDTH-1:0] BusW,
  output logic             Zero,
  output logic             Overflow,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] AccHi,
  output logic [WIDTH-1:0] AccLo
);

  localparam int         STEPS    = WIDTH / MUL_STEP_BITS;
  localparam logic [5:0] CNT_INIT = 6'(STEPS - 1);

  localparam logic [3:0] OP_AND  = 4'h0, OP_OR   = 4'h1, OP_ADD  = 4'h2, OP_SLL = 4'h3,
                         OP_SRL  = 4'h4, OP_MULA = 4'h5, OP_SUB  = 4'h6, OP_SLT = 4'h7,
                         OP_ADDU = 4'h8, OP_SUBU = 4'h9, OP_XOR  = 4'hA, OP_SLTU = 4'hB,
                         OP_NOR  = 4'hC, OP_SRA  = 4'hD, OP_LUI  = 4'hE;

  typedef enum logic [1:0] {IDLE, MUL, FIN} state_t;

  state_t             state;
  logic [5:0]         cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic               sign;

  logic [WIDTH-1:0]   res, sum, diff, abs_a, abs_b;
  logic               ovf;
  logic [2*WIDTH-1:0] partial, acc_next;

  always_comb begin
    sum  = BusA + BusB;
    diff = BusA - BusB;
    res  = '0;
    ovf  = 1'b0;
    case (ALUCtrl)
      OP_AND:  res = BusA & BusB;
      OP_OR:   res = BusA | BusB;
      OP_ADD: begin
        res = sum;
        ovf = (BusA[WIDTH-1] == BusB[WIDTH-1]) && (sum[WIDTH-1] != BusA[WIDTH-1]);
      end
      OP_SUB: begin
        res = diff;
        ovf = (BusA[WIDTH-1] != BusB[WIDTH-1]) && (diff[WIDTH-1] != BusA[WIDTH-1]);
      end
      OP_ADDU: res = sum;
      OP_SUBU: res = diff;
      OP_SLL:  res = BusB << Shamt;
      OP_SRL:  res = BusB >> Shamt;
      OP_SRA:  res = $signed(BusB) >>> Shamt;
      OP_SLT:  res = {{(WIDTH-1){1'b0}}, $signed(BusA) < $signed(BusB)};
      OP_SLTU: res = {{(WIDTH-1){1'b0}}, BusA < BusB};
      OP_XOR:  res = BusA ^ BusB;
      OP_NOR:  res = ~(BusA | BusB);
      OP_LUI:  res = {BusB[15:0], 16'h0};
      default: res = '0;
    endcase
  end

  // Magnitudes feed an unsigned shift-add; the sign is re-applied in FIN.
  assign abs_a = BusA[WIDTH-1] ? -BusA : BusA;
  assign abs_b = BusB[WIDTH-1] ? -BusB : BusB;

  always_comb begin
    partial = '0;
    for (int j = 0; j < MUL_STEP_BITS; j++)
      if (mplier[j]) partial = partial + (mcand << j);
  end

  assign acc_next = acc + (sign ? -prod : prod);

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state    <= IDLE;
      cnt      <= '0;
      acc      <= '0;
      prod     <= '0;
      mcand    <= '0;
      mplier   <= '0;
      sign     <= 1'b0;
      BusW     <= '0;
      Zero     <= 1'b1;
      Overflow <= 1'b0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          Done <= 1'b0;
          if (AccClr) acc <= '0;
          if (Start) begin
            if (ALUCtrl == OP_MULA) begin
              mcand  <= {{WIDTH{1'b0}}, abs_a};
              mplier <= abs_b;
              sign   <= BusA[WIDTH-1] ^ BusB[WIDTH-1];
              prod   <= '0;
              cnt    <= CNT_INIT;
              Busy   <= 1'b1;
              state  <= MUL;
            end else begin
              BusW     <= res;
              Zero     <= (res == '0);
              Overflow <= ovf;
              Done     <= 1'b1;
            end
          end
        end
        MUL: begin
          prod   <= prod + partial;
          mcand  <= mcand << MUL_STEP_BITS;
          mplier <= mplier >> MUL_STEP_BITS;
          if (cnt == 6'd0) state <= FIN;
          else             cnt   <= cnt - 6'd1;
        end
        FIN: begin
          acc      <= acc_next;
          BusW     <= acc_next[WIDTH-1:0];
          Zero     <= (acc_next[WIDTH-1:0] == '0);
          Overflow <= 1'b0;
          Done     <= 1'b1;
          Busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign AccHi = acc[2*WIDTH-1:WIDTH];
  assign AccLo = acc[WIDTH-1:0];

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle: single-cycle ops, MULA timing and
// accumulation, ignored Start/AccClr while busy, and reset mid-multiply.
module tb_alu_multicycle;

  logic        CLK = 1'b0;
  logic        Reset, Start, AccClr;
  logic [3:0]  ALUCtrl;
  logic [31:0] BusA, BusB;
  logic [4:0]  Shamt;
  logic [31:0] BusW, AccHi, AccLo;
  logic        Zero, Overflow, Busy, Done;

  logic [63:0] model_acc;
  int          checks = 0;
  int          errors = 0;

  alu_multicycle #(.WIDTH(32), .MUL_STEP_BITS(1)) dut (
    .CLK(CLK), .Reset(Reset), .Start(Start), .ALUCtrl(ALUCtrl),
    .BusA(BusA), .BusB(BusB), .Shamt(Shamt), .AccClr(AccClr),
    .BusW(BusW), .Zero(Zero), .Overflow(Overflow), .Busy(Busy),
    .Done(Done), .AccHi(AccHi), .AccLo(AccLo)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic alu_op(input string tag, input logic [3:0] c, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] sh,
                        input logic [31:0] w, input logic z, input logic o);
    @(negedge CLK);
    ALUCtrl = c; BusA = a; BusB = b; Shamt = sh; Start = 1'b1;
    @(posedge CLK); #1;
    Start = 1'b0;
    chk({tag, "_busw"}, BusW, w);
    chk({tag, "_zero"}, Zero, z);
    chk({tag, "_ovf"}, Overflow, o);
    chk({tag, "_done"}, Done, 1'b1);
    @(posedge CLK); #1;
    chk({tag, "_done_low"}, Done, 1'b0);
    chk({tag, "_hold"}, BusW, w);
  endtask

  task automatic mula(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic clr, input bit disturb);
    logic signed [63:0] sa, sb, p;
    int cyc, busy_n;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    p  = sa * sb;
    if (clr) model_acc = 64'h0;
    model_acc = model_acc + p;
    @(negedge CLK);
    ALUCtrl = 4'h5; BusA = a; BusB = b; Start = 1'b1; AccClr = clr;
    @(posedge CLK); #1;
    Start = 1'b0; AccClr = 1'b0;
    cyc = 1; busy_n = 0;
    while (!Done && cyc < 100) begin
      if (Busy) busy_n++;
      if (disturb && cyc == 5) begin
        Start = 1'b1; ALUCtrl = 4'h2; AccClr = 1'b1;
        BusA = 32'h1111_1111; BusB = 32'h2222_2222;
      end
      if (disturb && cyc == 6) begin
        Start = 1'b0; AccClr = 1'b0;
      end
      @(posedge CLK); #1;
      cyc++;
    end
    chk({tag, "_latency"}, 64'(cyc), 64'd34);
    chk({tag, "_busy_cycles"}, 64'(busy_n), 64'd33);
    chk({tag, "_busy_low"}, Busy, 1'b0);
    chk({tag, "_acc"}, {AccHi, AccLo}, model_acc);
    chk({tag, "_busw"}, BusW, model_acc[31:0]);
    chk({tag, "_zero"}, Zero, model_acc[31:0] == 32'h0);
    @(posedge CLK); #1;
    chk({tag, "_done_low"}, Done, 1'b0);
  endtask

  initial begin
    int done_n;
    Reset = 1'b1; Start = 1'b0; AccClr = 1'b0;
    ALUCtrl = 4'h0; BusA = '0; BusB = '0; Shamt = '0;
    model_acc = 64'h0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_busw", BusW, 32'h0);
    chk("rst_zero", Zero, 1'b1);
    chk("rst_ovf", Overflow, 1'b0);
    chk("rst_busy", Busy, 1'b0);
    chk("rst_done", Done, 1'b0);
    chk("rst_acc", {AccHi, AccLo}, 64'h0);
    @(negedge CLK);
    Reset = 1'b0;

    alu_op("add_ovf", 4'h2, 32'h7FFF_FFFF, 32'h1,         5'd0, 32'h8000_0000, 1'b0, 1'b1);
    alu_op("subu",    4'h9, 32'h5,         32'h5,         5'd0, 32'h0,         1'b1, 1'b0);
    alu_op("slt",     4'h7, 32'hFFFF_FFFF, 32'h1,         5'd0, 32'h1,         1'b0, 1'b0);
    alu_op("sltu",    4'hB, 32'hFFFF_FFFF, 32'h1,         5'd0, 32'h0,         1'b1, 1'b0);
    alu_op("sra",     4'hD, 32'h0,         32'h8000_0000, 5'd4, 32'hF800_0000, 1'b0, 1'b0);
    alu_op("srl",     4'h4, 32'h0,         32'h8000_0000, 5'd4, 32'h0800_0000, 1'b0, 1'b0);
    alu_op("lui",     4'hE, 32'h0,         32'h0000_1234, 5'd0, 32'h1234_0000, 1'b0, 1'b0);
    alu_op("sub_ovf", 4'h6, 32'h8000_0000, 32'h1,         5'd0, 32'h7FFF_FFFF, 1'b0, 1'b1);
    alu_op("sub_neg", 4'h6, 32'h3,         32'h5,         5'd0, 32'hFFFF_FFFE, 1'b0, 1'b0);
    alu_op("addu",    4'h8, 32'h7FFF_FFFF, 32'h1,         5'd0, 32'h8000_0000, 1'b0, 1'b0);
    alu_op("xor",     4'hA, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 32'h0FF0_0FF0, 1'b0, 1'b0);
    alu_op("nor",     4'hC, 32'h0,         32'h0,         5'd0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    alu_op("sll",     4'h3, 32'h0,         32'h1,         5'd31, 32'h8000_0000, 1'b0, 1'b0);
    alu_op("and",     4'h0, 32'hFF00_FF00, 32'h0F0F_0F0F, 5'd0, 32'h0F00_0F00, 1'b0, 1'b0);
    alu_op("or",      4'h1, 32'hFF00_0000, 32'h0000_00FF, 5'd0, 32'hFF00_00FF, 1'b0, 1'b0);
    alu_op("op_f",    4'hF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'h0,         1'b1, 1'b0);

    // -3*7 = -21 on a cleared accumulator; then +2^32 wraps modulo 2^64.
    mula("mula_neg", 32'hFFFF_FFFD, 32'h7,         1'b1, 1'b0);
    chk("mula_neg_const", {AccHi, AccLo}, 64'hFFFF_FFFF_FFFF_FFEB);
    mula("mula_big", 32'h0001_0000, 32'h0001_0000, 1'b0, 1'b0);
    chk("mula_big_const", {AccHi, AccLo}, 64'h0000_0000_FFFF_FFEB);
    mula("mula_dist", 32'h0000_0064, 32'hFFFF_FF9C, 1'b0, 1'b1);
    mula("mula_min",  32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0);
    chk("mula_min_const", {AccHi, AccLo}, 64'h4000_0000_0000_0000);

    @(negedge CLK);
    AccClr = 1'b1;
    @(posedge CLK); #1;
    AccClr = 1'b0;
    model_acc = 64'h0;
    chk("accclr_acc", {AccHi, AccLo}, 64'h0);
    chk("accclr_done", Done, 1'b0);

    mula("mula_pos", 32'h0000_1234, 32'h0000_5678, 1'b0, 1'b0);

    // Reset in the middle of a multiply: everything returns to reset values.
    @(negedge CLK);
    ALUCtrl = 4'h5; BusA = 32'h5; BusB = 32'h6; Start = 1'b1;
    @(posedge CLK); #1;
    Start = 1'b0;
    repeat (10) @(posedge CLK);
    @(negedge CLK);
    Reset = 1'b1;
    @(posedge CLK); #1;
    Reset = 1'b0;
    model_acc = 64'h0;
    chk("rstmid_acc", {AccHi, AccLo}, 64'h0);
    chk("rstmid_busy", Busy, 1'b0);
    chk("rstmid_done", Done, 1'b0);
    chk("rstmid_busw", BusW, 32'h0);
    chk("rstmid_zero", Zero, 1'b1);
    done_n = 0;
    repeat (40) begin
      @(posedge CLK); #1;
      if (Done) done_n++;
    end
    chk("rstmid_no_done", 64'(done_n), 64'd0);

    for (int i = 0; i < 12; i++)
      mula("mula_rand", $urandom, $urandom, 1'(i == 0), 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
